id_issue_arbiter: RTL and testbench

//  Shares the single ID->issue pipeline register between NR_REQ decoded-instruction sources
//  (req 0 = main decoder, others = debug program buffer / micro-op injectors).

---
 rtl/id_issue_arbiter_pkg.sv | 25 ++
 rtl/id_issue_arbiter_if.sv | 31 +++
 rtl/id_issue_arbiter_rr_pick.sv | 44 ++++
 rtl/id_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_id_issue_arbiter.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/id_issue_arbiter_pkg.sv
// Shared types for the ID->issue arbiter: FSM states, scoreboard entry, index-width helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package id_issue_arbiter_pkg;

    localparam int ID_ARB_MAX_REQ = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } id_arb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef scoreboard_entry_t sbe_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/id_issue_arbiter_if.sv
// Requester/issue bundle: per-source decoded entries plus the registered issue port.
// Latency: n/a (wiring only).
// Backpressure: issue_instr_ack_i from the issue side, req_ack_o towards the requesters.
interface id_issue_arbiter_if #(
    parameter int NR_REQ = 2
);
    import id_issue_arbiter_pkg::*;

    localparam int IW = idx_w(NR_REQ);

    sbe_t [NR_REQ-1:0] req_entry_i;
    logic [NR_REQ-1:0] req_ctrl_flow_i;
    logic [NR_REQ-1:0] req_valid_i;
    logic [NR_REQ-1:0] req_ack_o;
    sbe_t              issue_entry_o;
    logic              issue_entry_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_instr_ack_i;
    logic [IW-1:0]     grant_idx_o;

    modport master (
        input  req_entry_i, req_ctrl_flow_i, req_valid_i, issue_instr_ack_i,
        output req_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o, grant_idx_o
    );

    modport slave (
        output req_entry_i, req_ctrl_flow_i, req_valid_i, issue_instr_ack_i,
        input  req_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o, grant_idx_o
    );

endinterface

// File: rtl/id_issue_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after i_ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none.
module id_issue_arbiter_rr_pick
    import id_issue_arbiter_pkg::*;
#(
    parameter int NR_REQ = 2,
    parameter int IW     = idx_w(NR_REQ)
) (
    input  logic [NR_REQ-1:0] i_valid,
    input  logic [IW-1:0]     i_ptr,
    output logic [NR_REQ-1:0] o_onehot,
    output logic [IW-1:0]     o_idx,
    output logic              o_any
);

    logic          w_hi_any;
    logic [IW-1:0] w_hi_idx;
    logic          w_lo_any;
    logic [IW-1:0] w_lo_idx;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int j = NR_REQ - 1; j >= 0; j--) begin
            if (i_valid[j]) begin
                w_lo_any = 1'b1;
                w_lo_idx = IW'(j);
                if (j >= int'(i_ptr)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = IW'(j);
                end
            end
        end
    end

    assign o_any    = w_lo_any;
    assign o_idx    = w_hi_any ? w_hi_idx : w_lo_idx;
    assign o_onehot = NR_REQ'(1) << o_idx;

endmodule

// File: rtl/id_issue_arbiter.sv
// Shares the ID->issue register between NR_REQ sources; round-robin with burst lock (ID_ARB_STRICT_PRIO_EN: req 0 always wins).
// Latency: 1 cycle request->issue entry, one load per cycle while issue acks every cycle.
// Backpressure: req_ack_o only when the register is empty or being acked, never during flush.
module id_issue_arbiter
    import id_issue_arbiter_pkg::*;
#(
    parameter int NR_REQ    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    id_issue_arbiter_if.master bus
);

    localparam int IW = idx_w(NR_REQ);

    id_arb_state_e r_state,  w_state;
    logic          r_valid,  w_valid;
    sbe_t          r_entry,  w_entry;
    logic          r_cf,     w_cf;
    logic [IW-1:0] r_gidx,   w_gidx;
    logic [IW-1:0] r_rr_ptr, w_rr_ptr;
    logic [3:0]    r_burst,  w_burst;

    logic              w_space;
    logic [NR_REQ-1:0] w_rr_onehot;
    logic [IW-1:0]     w_rr_idx;
    logic              w_rr_any;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_preempt;
    logic              w_load;
    logic [3:0]        w_burst_inc;

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
        if (int'(i) == NR_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    id_issue_arbiter_rr_pick #(
        .NR_REQ (NR_REQ),
        .IW     (IW)
    ) u_rr_pick (
        .i_valid  (bus.req_valid_i),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_rr_onehot),
        .o_idx    (w_rr_idx),
        .o_any    (w_rr_any)
    );

    assign w_space = !r_valid || bus.issue_instr_ack_i;

    // While locked the owner is the last loaded index, so r_gidx doubles as the lock owner.
    always_comb begin
        w_pick_idx = w_rr_idx;
        w_pick_any = w_rr_any;
        w_preempt  = 1'b0;
        if (r_state == LOCKED) begin
            w_pick_idx = r_gidx;
            w_pick_any = bus.req_valid_i[r_gidx];
        end
`ifdef ID_ARB_STRICT_PRIO_EN
        if (bus.req_valid_i[0]) begin
            w_pick_idx = '0;
            w_pick_any = 1'b1;
            w_preempt  = (r_state == LOCKED) && (r_gidx != '0);
        end
`else
        w_preempt  = 1'b0;
`endif
    end

    assign w_load        = rst_ni && !flush_i && w_space && w_pick_any;
    assign bus.req_ack_o = w_load ? (NR_REQ'(1) << w_pick_idx) : '0;
    assign w_burst_inc   = (r_state == IDLE) ? 4'd1 : r_burst + 4'd1;

    always_comb begin
        w_state  = r_state;
        w_valid  = r_valid;
        w_entry  = r_entry;
        w_cf     = r_cf;
        w_gidx   = r_gidx;
        w_rr_ptr = r_rr_ptr;
        w_burst  = r_burst;
        if (flush_i) begin
            w_valid = 1'b0;
            w_state = IDLE;
            w_burst = 4'd0;
        end else begin
            if (w_load) begin
                w_valid = 1'b1;
                w_entry = bus.req_entry_i[w_pick_idx];
                w_cf    = bus.req_ctrl_flow_i[w_pick_idx];
                w_gidx  = w_pick_idx;
            end else if (bus.issue_instr_ack_i) begin
                w_valid = 1'b0;
            end

            if (w_load && w_preempt) begin
                // Point back at the preempted owner so it resumes first.
                w_state  = IDLE;
                w_burst  = 4'd0;
                w_rr_ptr = r_gidx;
            end else if (w_load) begin
                if (bus.req_ctrl_flow_i[w_pick_idx] || (w_burst_inc == 4'(MAX_BURST))) begin
                    w_state  = IDLE;
                    w_burst  = 4'd0;
                    w_rr_ptr = nxt_idx(w_pick_idx);
                end else begin
                    w_state = LOCKED;
                    w_burst = w_burst_inc;
                end
            end else if ((r_state == LOCKED) && w_space && !bus.req_valid_i[r_gidx]) begin
                w_state  = IDLE;
                w_burst  = 4'd0;
                w_rr_ptr = nxt_idx(r_gidx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_entry  <= '0;
            r_cf     <= 1'b0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_burst  <= 4'd0;
        end else begin
            r_state  <= w_state;
            r_valid  <= w_valid;
            r_entry  <= w_entry;
            r_cf     <= w_cf;
            r_gidx   <= w_gidx;
            r_rr_ptr <= w_rr_ptr;
            r_burst  <= w_burst;
        end
    end

    assign bus.issue_entry_o       = r_entry;
    assign bus.issue_entry_valid_o = r_valid;
    assign bus.is_ctrl_flow_o      = r_cf;
    assign bus.grant_idx_o         = r_gidx;

endmodule

// File: tb/tb_id_issue_arbiter.sv
// Directed bench for id_issue_arbiter with NR_REQ=2, MAX_BURST=4.
// Latency: checks combinational ack before each edge and the registered entry after it.
// Backpressure: exercised through issue_instr_ack_i stalls and flush.
module tb_id_issue_arbiter;
    import id_issue_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_issue_arbiter_if #(.NR_REQ(2)) bus ();

    id_issue_arbiter #(
        .NR_REQ    (2),
        .MAX_BURST (4)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic sbe_t mk(input logic [31:0] pc, input logic [7:0] op);
        sbe_t e;
        e.pc = pc;
        e.op = op;
        e.rd = 5'd0;
        return e;
    endfunction

    // Inputs are set by the caller just after an edge; ack is sampled mid-cycle.
    task automatic tick(input string tag, input logic [1:0] e_ack, input logic e_vld,
                        input logic e_gnt, input logic [31:0] e_pc, input logic e_cf);
        #1;
        chk($sformatf("%s.ack", tag), 32'(bus.req_ack_o), 32'(e_ack));
        @(posedge clk);
        #1;
        chk($sformatf("%s.vld", tag), 32'(bus.issue_entry_valid_o), 32'(e_vld));
        chk($sformatf("%s.gnt", tag), 32'(bus.grant_idx_o), 32'(e_gnt));
        if (e_vld) begin
            chk($sformatf("%s.pc", tag), bus.issue_entry_o.pc, e_pc);
            chk($sformatf("%s.cf", tag), 32'(bus.is_ctrl_flow_o), 32'(e_cf));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid_i       = 2'b11;
        bus.req_ctrl_flow_i   = 2'b00;
        bus.issue_instr_ack_i = 1'b1;
        bus.req_entry_i[0]    = mk(32'h100, 8'd0);
        bus.req_entry_i[1]    = mk(32'h200, 8'd1);
        #1;
        chk("rst.ack", 32'(bus.req_ack_o), 32'd0);
        @(posedge clk);
        #1;
        chk("rst.vld", 32'(bus.issue_entry_valid_o), 32'd0);
        chk("rst.gnt", 32'(bus.grant_idx_o), 32'd0);
        chk("rst.cf",  32'(bus.is_ctrl_flow_o), 32'd0);
        chk("rst.pc",  bus.issue_entry_o.pc, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic g2 [9];
        g2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset then first grant goes to requester 0.
        do_reset();
        tick("t1", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);

        // Burst lock of 4, then rotation.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick($sformatf("t2[%0d]", i), g2[i] ? 2'b10 : 2'b01, 1'b1, g2[i],
                 g2[i] ? 32'h200 : 32'h100, 1'b0);
        end

        // Control-flow entry releases the lock early.
        do_reset();
        tick("t3a", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);
        bus.req_ctrl_flow_i = 2'b01;
        tick("t3b", 2'b01, 1'b1, 1'b0, 32'h100, 1'b1);
        bus.req_ctrl_flow_i = 2'b00;
        tick("t3c", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);

        // Issue stall holds the entry even though the source changes.
        do_reset();
        tick("t4a", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);
        bus.issue_instr_ack_i = 1'b0;
        bus.req_entry_i[0]    = mk(32'h111, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick($sformatf("t4s[%0d]", i), 2'b00, 1'b1, 1'b0, 32'h100, 1'b0);
        end
        bus.issue_instr_ack_i = 1'b1;
        tick("t4b", 2'b01, 1'b1, 1'b0, 32'h111, 1'b0);

        // Flush drops the entry and the lock on requester 1; rr_ptr stays 0.
        do_reset();
        bus.req_valid_i = 2'b10;
        tick("t5a", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);
        bus.req_valid_i = 2'b11;
        flush = 1'b1;
        tick("t5f", 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        flush = 1'b0;
        tick("t5b", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);

        // Owner dropping valid releases the lock and advances rr_ptr.
        do_reset();
        tick("t7a", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);
        bus.req_valid_i = 2'b10;
        tick("t7b", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.req_valid_i = 2'b11;
        tick("t7c", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);

        // Requester 0 rising while 1 holds the lock.
        do_reset();
        bus.req_valid_i = 2'b10;
        tick("t6a", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);
        bus.req_valid_i = 2'b11;
`ifdef ID_ARB_STRICT_PRIO_EN
        tick("t6b", 2'b01, 1'b1, 1'b0, 32'h100, 1'b0);
        bus.req_valid_i = 2'b10;
        tick("t6c", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);
`else
        tick("t6b", 2'b10, 1'b1, 1'b1, 32'h200, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
